// File: rtl/async_fifo_pkg.sv
// Shared definitions for the single-clock FIFO slice.
// Provides default geometry, the address-width helper and the default
// pointer type (address bits plus one wrap bit).
package async_fifo_pkg;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_DEPTH = 8;

    // Address width for a given depth; depth is expected to be a power of two.
    function automatic int unsigned aw_of(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    localparam int unsigned DEF_AW = aw_of(DEF_DEPTH);

    // Pointer for the default geometry: MSB is the wrap bit.
    typedef logic [DEF_AW:0] ptr_t;

    // Returns 1 when depth is a power of two and at least 2.
    function automatic bit depth_ok(input int unsigned depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/async_fifo_core_if.sv
// Producer/consumer bundle for async_fifo_core.
// master: drives i_wdata/i_push/i_pop, observes o_full/o_empty/o_rdata.
// slave : the FIFO side.
interface async_fifo_core_if
    import async_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);
    logic [WIDTH-1:0] i_wdata;
    logic             i_push;
    logic             i_pop;
    logic             o_full;
    logic             o_empty;
    logic [WIDTH-1:0] o_rdata;

    modport master (
        output i_wdata, i_push, i_pop,
        input  o_full, o_empty, o_rdata
    );

    modport slave (
        input  i_wdata, i_push, i_pop,
        output o_full, o_empty, o_rdata
    );
endinterface

// File: rtl/async_fifo_ram.sv
// Simple dual-port storage for the FIFO.
// i_clk/i_rst_n : clock and asynchronous active-low reset (read register only)
// i_we/i_waddr/i_wdata : write port
// i_re/i_raddr : read request/address
// o_rdata : registered read data, holds when i_re=0, cleared by reset
module async_fifo_ram
    import async_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned AW    = DEF_AW
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);
    localparam int unsigned DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Array is deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rdata_q <= '0;
        end else if (i_re) begin
            rdata_q <= mem_q[i_raddr];
        end
    end

    assign o_rdata = rdata_q;
endmodule

// File: rtl/async_fifo_core.sv
// Single-clock FIFO with exact full/empty flags.
// i_clk   : clock, all state updates on rising edge
// i_rst_n : asynchronous active-low reset (pointers and read data cleared)
// bus     : slave side of async_fifo_core_if (push/pop, data, flags)
// Pointers carry one extra wrap bit; equal pointers mean empty, pointers
// differing only in the wrap bit mean full.
module async_fifo_core
    import async_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    async_fifo_core_if.slave     bus
);
    localparam int unsigned AW = aw_of(DEPTH);

    typedef logic [AW:0] fptr_t;

    generate
        if (!depth_ok(DEPTH)) begin : g_bad_depth
            $fatal(1, "async_fifo_core: DEPTH must be a power of two >= 2");
        end
    endgenerate

    fptr_t wptr_q, wptr_d;
    fptr_t rptr_q, rptr_d;
    logic  full, empty;
    logic  push_ok, pop_ok;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    // Both accepts are judged against the pre-edge flags, so push+pop on a
    // full FIFO only pops and on an empty FIFO only pushes.
    assign push_ok = bus.i_push & ~full;
    assign pop_ok  = bus.i_pop  & ~empty;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_ok) wptr_d = wptr_q + fptr_t'(1);
        if (pop_ok)  rptr_d = rptr_q + fptr_t'(1);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    async_fifo_ram #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_ram (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_we    (push_ok),
        .i_waddr (wptr_q[AW-1:0]),
        .i_wdata (bus.i_wdata),
        .i_re    (pop_ok),
        .i_raddr (rptr_q[AW-1:0]),
        .o_rdata (bus.o_rdata)
    );

    assign bus.o_full  = full;
    assign bus.o_empty = empty;
endmodule

// File: tb/tb_async_fifo_core.sv
// Directed self-checking bench for async_fifo_core (WIDTH=16, DEPTH=8).
module tb_async_fifo_core;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    async_fifo_core_if #(.WIDTH(16)) bus ();

    async_fifo_core #(
        .WIDTH (16),
        .DEPTH (8)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        bus.i_push  = 1'b0;
        bus.i_pop   = 1'b0;
        bus.i_wdata = '0;
        step();
        step();
        rst_n = 1'b1;
        step();

        // Post-reset state
        check("rst_empty", 32'(bus.o_empty), 32'd1);
        check("rst_full",  32'(bus.o_full),  32'd0);
        check("rst_rdata", 32'(bus.o_rdata), 32'h0);

        // Two pushes then two pops
        bus.i_push = 1'b1; bus.i_wdata = 16'h0005;
        step();
        check("p1_empty", 32'(bus.o_empty), 32'd0);
        bus.i_wdata = 16'h0017;
        step();
        bus.i_push = 1'b0; bus.i_pop = 1'b1;
        step();
        check("pop1_data", 32'(bus.o_rdata), 32'h0005);
        check("pop1_empty", 32'(bus.o_empty), 32'd0);
        step();
        check("pop2_data", 32'(bus.o_rdata), 32'h0017);
        check("pop2_empty", 32'(bus.o_empty), 32'd1);
        bus.i_pop = 1'b0;

        // Overfill: 16 pushes, only first 8 stored
        for (int i = 0; i < 16; i++) begin
            bus.i_push = 1'b1; bus.i_wdata = 16'(i);
            step();
            if (i == 6) check("fill7_full", 32'(bus.o_full), 32'd0);
            if (i == 7) check("fill8_full", 32'(bus.o_full), 32'd1);
            if (i == 15) check("fill16_full", 32'(bus.o_full), 32'd1);
        end
        bus.i_push = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.i_pop = 1'b1;
            step();
            check($sformatf("drain%0d_data", i), 32'(bus.o_rdata), 32'(i));
            if (i == 0) check("drain0_full", 32'(bus.o_full), 32'd0);
        end
        check("drain_empty", 32'(bus.o_empty), 32'd1);

        // Pop on empty for 3 cycles: data and flags hold
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("uflow%0d_data", i), 32'(bus.o_rdata), 32'h0007);
            check($sformatf("uflow%0d_empty", i), 32'(bus.o_empty), 32'd1);
        end
        bus.i_pop = 1'b0;

        // Wrap-around with steady fill level of 3
        for (int i = 0; i < 3; i++) begin
            bus.i_push = 1'b1; bus.i_wdata = 16'(16'h0100 + i);
            step();
        end
        for (int k = 0; k < 20; k++) begin
            bus.i_push = 1'b1; bus.i_pop = 1'b1;
            bus.i_wdata = 16'(16'h0103 + k);
            step();
            check($sformatf("wrap%0d_data", k), 32'(bus.o_rdata), 32'(16'h0100 + k));
            check($sformatf("wrap%0d_flags", k), {30'd0, bus.o_full, bus.o_empty}, 32'd0);
        end
        bus.i_push = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("wdrain%0d_data", i), 32'(bus.o_rdata), 32'(16'h0114 + i));
        end
        check("wdrain_empty", 32'(bus.o_empty), 32'd1);
        bus.i_pop = 1'b0;

        // Full with simultaneous push+pop: pop wins, push dropped
        for (int i = 0; i < 8; i++) begin
            bus.i_push = 1'b1; bus.i_wdata = 16'(16'h0200 + i);
            step();
        end
        check("f_full", 32'(bus.o_full), 32'd1);
        bus.i_wdata = 16'h00AA; bus.i_pop = 1'b1;
        step();
        check("fpp_data", 32'(bus.o_rdata), 32'h0200);
        check("fpp_full", 32'(bus.o_full), 32'd0);
        bus.i_push = 1'b0;
        for (int i = 1; i < 8; i++) begin
            step();
            check($sformatf("fdrain%0d_data", i), 32'(bus.o_rdata), 32'(16'h0200 + i));
        end
        check("fdrain_empty", 32'(bus.o_empty), 32'd1);
        bus.i_pop = 1'b0;

        // Asynchronous reset mid-cycle with data present
        bus.i_push = 1'b1; bus.i_wdata = 16'h0033;
        step();
        bus.i_wdata = 16'h0044;
        step();
        bus.i_push = 1'b0; bus.i_pop = 1'b1;
        step();
        bus.i_pop = 1'b0;
        check("prerst_data", 32'(bus.o_rdata), 32'h0033);
        check("prerst_empty", 32'(bus.o_empty), 32'd0);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_empty", 32'(bus.o_empty), 32'd1);
        check("arst_full",  32'(bus.o_full),  32'd0);
        check("arst_rdata", 32'(bus.o_rdata), 32'h0);
        // Requests during reset are ignored
        bus.i_push = 1'b1; bus.i_wdata = 16'h0099;
        #19;
        check("inrst_empty", 32'(bus.o_empty), 32'd1);
        bus.i_push = 1'b0;
        rst_n = 1'b1;
        step();
        check("postrst_empty", 32'(bus.o_empty), 32'd1);
        check("postrst_rdata", 32'(bus.o_rdata), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
